// File: rtl/laundry_bay_scheduler.sv
// laundry_bay_scheduler: queues paid wash jobs and dispatches them round-robin to idle machines,
// fencing off machines that never acknowledge a start.
module laundry_bay_scheduler #(
  parameter int NUM_MACHINES = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [1:0]                    req_mode,
  output logic                          req_ready,
  input  logic [NUM_MACHINES-1:0]       machine_idle,
  input  logic [NUM_MACHINES-1:0]       fault_clear,
  output logic [NUM_MACHINES-1:0]       start_pulse,
  output logic [1:0]                    start_mode,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic [NUM_MACHINES-1:0]       machine_fault,
  output logic [7:0]                    reject_count
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = $clog2(NUM_MACHINES);
  logic [1:0] mem [QUEUE_DEPTH];
  logic [AW-1:0] head, tail;
  logic [PW-1:0] rr, grant, idx;
  logic [NUM_MACHINES-1:0] reserved, reserved_n, eligible, timeout, grant_oh;
  logic [7:0] timer [NUM_MACHINES];
  logic push, pop;
  logic [9:0] rej_sum;
  assign req_ready = int'(queue_count) < QUEUE_DEPTH;
  assign push = req_valid && req_ready && req_mode != 2'd3;
  assign eligible = machine_idle & ~reserved & ~machine_fault;
  assign pop = queue_count != '0 && |eligible;
  assign grant_oh = pop ? NUM_MACHINES'(1) << grant : '0;
  assign reserved_n = (reserved & machine_idle & ~timeout) | grant_oh;
  // Scan downward so the closest eligible index at or after rr is the last one kept.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_MACHINES - 1; k >= 0; k--) begin
      idx = PW'((int'(rr) + k) % NUM_MACHINES);
      if (eligible[idx]) grant = idx;
    end
  end
  always_comb begin
    timeout = '0;
    for (int k = 0; k < NUM_MACHINES; k++)
      timeout[k] = reserved[k] && machine_idle[k] && timer[k] == 8'(ACK_TIMEOUT - 1);
  end
  // Lost jobs from timeouts and dropped requests can land on the same edge.
  always_comb begin
    rej_sum = {2'b0, reject_count} + {9'b0, req_valid && !push};
    for (int k = 0; k < NUM_MACHINES; k++) rej_sum = rej_sum + {9'b0, timeout[k]};
  end
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= req_mode;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      queue_count <= '0;
      rr <= '0;
      reserved <= '0;
      machine_fault <= '0;
      reject_count <= '0;
      start_pulse <= '0;
      start_mode <= '0;
      for (int k = 0; k < NUM_MACHINES; k++) timer[k] <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      if (pop) rr <= grant == PW'(NUM_MACHINES - 1) ? '0 : grant + PW'(1);
      queue_count <= queue_count + (AW+1)'(push) - (AW+1)'(pop);
      start_pulse <= grant_oh;
      start_mode <= pop ? mem[head] : 2'd0;
      reserved <= reserved_n;
      machine_fault <= (machine_fault & ~fault_clear) | timeout;
      reject_count <= rej_sum > 10'd255 ? 8'hff : rej_sum[7:0];
      for (int k = 0; k < NUM_MACHINES; k++)
        timer[k] <= reserved[k] && machine_idle[k] && !timeout[k] ? timer[k] + 8'd1 : 8'd0;
    end
  end
endmodule

// File: tb/tb_laundry_bay_scheduler.sv
// tb_laundry_bay_scheduler: directed vector table plus hand-written timeout and async-reset sequences.
module tb_laundry_bay_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic req_ready;
  logic [3:0] machine_idle = 4'b0;
  logic [3:0] fault_clear = 4'b0;
  logic [3:0] start_pulse;
  logic [1:0] start_mode;
  logic [3:0] queue_count;
  logic [3:0] machine_fault;
  logic [7:0] reject_count;
  int passed = 0;
  int total = 0;

  typedef struct {
    logic rst, valid;
    logic [1:0] mode;
    logic [3:0] idle, fclr, e_pulse;
    logic [1:0] e_mode;
    logic [3:0] e_qc;
    logic e_rdy;
    logic [3:0] e_fault;
    logic [7:0] e_rej;
  } row_t;

  row_t tbl[$];

  laundry_bay_scheduler #(.NUM_MACHINES(4), .QUEUE_DEPTH(8), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .machine_idle(machine_idle), .fault_clear(fault_clear), .start_pulse(start_pulse),
    .start_mode(start_mode), .queue_count(queue_count), .machine_fault(machine_fault),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic rst, input logic valid, input logic [1:0] mode,
                              input logic [3:0] idle, input logic [3:0] fclr, input logic [3:0] e_pulse,
                              input logic [1:0] e_mode, input logic [3:0] e_qc, input logic e_rdy,
                              input logic [3:0] e_fault, input logic [7:0] e_rej);
    row_t r;
    r.rst = rst; r.valid = valid; r.mode = mode; r.idle = idle; r.fclr = fclr;
    r.e_pulse = e_pulse; r.e_mode = e_mode; r.e_qc = e_qc; r.e_rdy = e_rdy;
    r.e_fault = e_fault; r.e_rej = e_rej;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic check_outputs(input row_t r, input string tag);
    chk({tag, ".start_pulse"}, 32'(start_pulse), 32'(r.e_pulse));
    if (r.e_pulse != 4'b0) chk({tag, ".start_mode"}, 32'(start_mode), 32'(r.e_mode));
    chk({tag, ".queue_count"}, 32'(queue_count), 32'(r.e_qc));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(r.e_rdy));
    chk({tag, ".machine_fault"}, 32'(machine_fault), 32'(r.e_fault));
    chk({tag, ".reject_count"}, 32'(reject_count), 32'(r.e_rej));
  endtask

  task automatic run(input row_t r, input string tag);
    reset = r.rst;
    req_valid = r.valid;
    req_mode = r.mode;
    machine_idle = r.idle;
    fault_clear = r.fclr;
    @(posedge clk);
    #1;
    check_outputs(r, tag);
  endtask

  initial begin
    // single job, ack, and proof that the reservation on machine 0 was released
    tbl.push_back(mk(1, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1111, 0, 4'b0000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 4'b0001, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1110, 0, 4'b0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 4'b0001, 0, 4'b0000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0001, 0, 4'b0001, 2, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0));
    // back-to-back jobs rotate across all four machines
    tbl.push_back(mk(1, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b1111, 0, 4'b0000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1111, 0, 4'b0001, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 4'b1110, 0, 4'b0010, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b1100, 0, 4'b0100, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1000, 0, 4'b1000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0));
    // illegal mode, fill to full, overflow, then pop and push on the same edge while full
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 2'(i % 3), 4'b0000, 0, 4'b0000, 0, 4'(i + 1), i < 7, 0, 1));
    tbl.push_back(mk(0, 1, 2, 4'b0000, 0, 4'b0000, 0, 8, 0, 0, 2));
    tbl.push_back(mk(0, 1, 3, 4'b0000, 0, 4'b0000, 0, 8, 0, 0, 3));
    tbl.push_back(mk(0, 1, 2, 4'b0001, 0, 4'b0001, 0, 7, 1, 0, 4));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 0, 4'b0000, 0, 8, 0, 0, 4));

    #1;
    chk("async_reset.start_pulse", 32'(start_pulse), 0);
    chk("async_reset.req_ready", 32'(req_ready), 1);
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("row%0d", i));

    // ack timeout on machine 2; a clear on the same edge loses to the new fault
    run(mk(1, 0, 0, 4'b0100, 0, 4'b0000, 0, 0, 1, 0, 0), "to.reset");
    run(mk(0, 1, 2, 4'b0100, 0, 4'b0000, 0, 1, 1, 0, 0), "to.push");
    run(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 2, 0, 1, 0, 0), "to.dispatch");
    for (int i = 1; i <= 15; i++)
      run(mk(0, 0, 0, 4'b0100, 0, 4'b0000, 0, 0, 1, 0, 0), $sformatf("to.wait%0d", i));
    run(mk(0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 1), "to.fire");
    run(mk(0, 1, 1, 4'b0110, 0, 4'b0000, 0, 1, 1, 4'b0100, 1), "to.push2");
    run(mk(0, 0, 0, 4'b0110, 0, 4'b0010, 1, 0, 1, 4'b0100, 1), "to.skip");
    run(mk(0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 0, 1, 4'b0000, 1), "to.clear");
    run(mk(0, 1, 0, 4'b0100, 0, 4'b0000, 0, 1, 1, 0, 1), "to.push3");
    run(mk(0, 0, 0, 4'b0100, 0, 4'b0100, 0, 0, 1, 0, 1), "to.regrant");

    // reset mid-cycle with five queued jobs and two outstanding reservations
    run(mk(1, 0, 0, 4'b0011, 0, 4'b0000, 0, 0, 1, 0, 0), "mr.reset");
    run(mk(0, 1, 0, 4'b0011, 0, 4'b0000, 0, 1, 1, 0, 0), "mr.s1");
    run(mk(0, 1, 1, 4'b0011, 0, 4'b0001, 0, 1, 1, 0, 0), "mr.s2");
    run(mk(0, 1, 2, 4'b0011, 0, 4'b0010, 1, 1, 1, 0, 0), "mr.s3");
    for (int i = 0; i < 4; i++)
      run(mk(0, 1, 2'(i % 3), 4'b0011, 0, 4'b0000, 0, 4'(i + 2), 1, 0, 0), $sformatf("mr.fill%0d", i));
    #3;
    reset = 1'b1;
    req_valid = 1'b0;
    machine_idle = 4'b1111;
    #1;
    check_outputs(mk(1, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 0), "mr.immediate");
    #2;
    reset = 1'b0;
    for (int i = 0; i < 20; i++)
      run(mk(0, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 1, 0, 0), $sformatf("mr.quiet%0d", i));
    run(mk(0, 1, 1, 4'b1111, 0, 4'b0000, 0, 1, 1, 0, 0), "mr.new");
    run(mk(0, 0, 0, 4'b1111, 0, 4'b0001, 1, 0, 1, 0, 0), "mr.newgrant");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
